// File: rtl/step_count_monitor.sv
// Receive-side checker for a stepped counter stream: verifies the step between
// accepted samples, flags idle timeouts and requests a stop when THRESHOLD arrives.
module step_count_monitor #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned STEP      = 10,
   parameter int unsigned THRESHOLD = 100,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample_value,
   input  logic             stop_ack,
   output logic             stop_req,
   output logic             stop_flag,
   output logic             step_err,
   output logic             timeout_err,
   output logic [15:0]      sample_cnt,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      TRACK = 3'd2,
      REQ   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int unsigned      IW       = $clog2(TIMEOUT + 1);
   localparam logic [WIDTH-1:0] THR      = WIDTH'(THRESHOLD);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [IW-1:0]    TO_LIMIT = IW'(TIMEOUT);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  prev;
   logic [IW-1:0]     idle_cnt;
   logic              accept;
   logic              at_thr;

   // enable=0 in ARM/TRACK takes priority over a sample on the same edge
   assign accept = sample_valid && enable && ((state_q == ARM) || (state_q == TRACK));
   assign at_thr = (sample_value == THR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (enable) state_d = ARM;
         ARM, TRACK: begin
            if (!enable)              state_d = IDLE;
            else if (accept && at_thr) state_d = REQ;
            else if (accept)           state_d = TRACK;
         end
         REQ:   if (stop_ack) state_d = DONE;
         DONE:  state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         prev        <= '0;
         idle_cnt    <= '0;
         step_err    <= 1'b0;
         timeout_err <= 1'b0;
         stop_flag   <= 1'b0;
         sample_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            prev <= sample_value;
            if (sample_cnt != '1) sample_cnt <= sample_cnt + 16'd1;
            if ((state_q == TRACK) && (sample_value != prev + STEP_W)) step_err <= 1'b1;
            if (at_thr) stop_flag <= 1'b1;
         end
         // idle counter saturates at TIMEOUT; anything other than an idle TRACK cycle clears it
         if ((state_q == TRACK) && enable && !sample_valid) begin
            if (idle_cnt != TO_LIMIT) idle_cnt <= idle_cnt + IW'(1);
            if (idle_cnt == TO_LIMIT - IW'(1)) timeout_err <= 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign stop_req = (state_q == REQ);
   assign state    = state_q;

endmodule

// File: tb/tb_step_count_monitor.sv
// Directed bench for step_count_monitor: default, 8-bit and short-timeout instances
// share one stimulus stream; each test checks the instance it targets.
module tb_step_count_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [31:0] sample_value = '0;
   logic        stop_ack = 1'b0;

   logic        m_req, m_flag, m_serr, m_terr;
   logic [15:0] m_cnt;
   logic [2:0]  m_state;
   logic        b_req, b_flag, b_serr, b_terr;
   logic [15:0] b_cnt;
   logic [2:0]  b_state;
   logic        t_req, t_flag, t_serr, t_terr;
   logic [15:0] t_cnt;
   logic [2:0]  t_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   step_count_monitor #(.WIDTH(32), .STEP(10), .THRESHOLD(100), .TIMEOUT(16)) u_main (
      .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .sample_value(sample_value), .stop_ack(stop_ack), .stop_req(m_req),
      .stop_flag(m_flag), .step_err(m_serr), .timeout_err(m_terr),
      .sample_cnt(m_cnt), .state(m_state));

   step_count_monitor #(.WIDTH(8), .STEP(10), .THRESHOLD(100), .TIMEOUT(16)) u_b8 (
      .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .sample_value(sample_value[7:0]), .stop_ack(stop_ack), .stop_req(b_req),
      .stop_flag(b_flag), .step_err(b_serr), .timeout_err(b_terr),
      .sample_cnt(b_cnt), .state(b_state));

   step_count_monitor #(.WIDTH(32), .STEP(10), .THRESHOLD(100), .TIMEOUT(4)) u_to (
      .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
      .sample_value(sample_value), .stop_ack(stop_ack), .stop_req(t_req),
      .stop_flag(t_flag), .step_err(t_serr), .timeout_err(t_terr),
      .sample_cnt(t_cnt), .state(t_state));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_value = '0; stop_ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [31:0] v);
      sample_valid = 1'b1;
      sample_value = v;
      tick();
      sample_valid = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst_state", m_state, 0);
      check("rst_req", m_req, 0);
      check("rst_flag", m_flag, 0);
      check("rst_serr", m_serr, 0);
      check("rst_terr", m_terr, 0);
      check("rst_cnt", m_cnt, 0);

      // T1: 0..100 in steps of 10, then ack after 3 REQ cycles
      enable = 1'b1;
      tick();
      check("t1_arm", m_state, 1);
      for (int i = 0; i <= 9; i++) send(32'(i * 10));
      check("t1_track", m_state, 2);
      check("t1_noreq_yet", m_req, 0);
      send(32'd100);
      check("t1_req", m_req, 1);
      check("t1_flag", m_flag, 1);
      check("t1_cnt", m_cnt, 11);
      check("t1_serr", m_serr, 0);
      enable = 1'b0;
      tick();
      check("t1_req_hold_en0", m_state, 3);
      tick();
      check("t1_req_hold", m_req, 1);
      stop_ack = 1'b1;
      tick();
      stop_ack = 1'b0;
      check("t1_done", m_state, 4);
      check("t1_req_drop", m_req, 0);
      check("t1_flag_kept", m_flag, 1);
      enable = 1'b1;
      send(32'd110);
      check("t1_done_ignore_cnt", m_cnt, 11);
      check("t1_done_stays", m_state, 4);

      // T2: step error on 25, sticky, tracking continues
      do_reset();
      enable = 1'b1;
      tick();
      send(32'd0);
      send(32'd10);
      check("t2_no_err_yet", m_serr, 0);
      send(32'd25);
      check("t2_err", m_serr, 1);
      send(32'd35);
      send(32'd45);
      check("t2_err_sticky", m_serr, 1);
      check("t2_state", m_state, 2);
      check("t2_cnt", m_cnt, 5);

      // T3: 8-bit wrap-around is not a step error
      do_reset();
      enable = 1'b1;
      tick();
      send(32'd240);
      send(32'd250);
      send(32'd4);
      send(32'd14);
      check("t3_b8_serr", b_serr, 0);
      check("t3_b8_cnt", b_cnt, 4);
      check("t3_b8_state", b_state, 2);
      check("t3_w32_serr", m_serr, 1);

      // T4: timeout after 4 idle TRACK cycles, then 16 on the default instance
      do_reset();
      enable = 1'b1;
      tick();
      send(32'd0);
      send(32'd10);
      for (int i = 0; i < 3; i++) tick();
      check("t4_no_to_at3", t_terr, 0);
      tick();
      check("t4_to_at4", t_terr, 1);
      check("t4_to_state", t_state, 2);
      check("t4_main_no_to", m_terr, 0);
      send(32'd20);
      check("t4_serr_after", t_serr, 0);
      check("t4_to_sticky", t_terr, 1);
      for (int i = 0; i < 15; i++) tick();
      check("t4_main_no_to_at15", m_terr, 0);
      tick();
      check("t4_main_to_at16", m_terr, 1);

      // T5: threshold as base sample, ack in first REQ cycle
      do_reset();
      enable = 1'b1;
      tick();
      send(32'd100);
      check("t5_req_state", m_state, 3);
      check("t5_req", m_req, 1);
      check("t5_cnt", m_cnt, 1);
      stop_ack = 1'b1;
      send(32'd110);
      stop_ack = 1'b0;
      check("t5_done", m_state, 4);
      check("t5_cnt_ignored", m_cnt, 1);
      check("t5_req_drop", m_req, 0);
      check("t5_flag", m_flag, 1);

      // T6: reset from REQ; enable low in TRACK keeps flags and drops the sample
      do_reset();
      enable = 1'b1;
      tick();
      send(32'd100);
      check("t6_in_req", m_state, 3);
      rst = 1'b1;
      stop_ack = 1'b1;
      tick();
      rst = 1'b0;
      stop_ack = 1'b0;
      check("t6_rst_state", m_state, 0);
      check("t6_rst_req", m_req, 0);
      check("t6_rst_flag", m_flag, 0);
      check("t6_rst_cnt", m_cnt, 0);
      tick();
      send(32'd0);
      send(32'd15);
      check("t6_serr", m_serr, 1);
      enable = 1'b0;
      send(32'd25);
      check("t6_idle", m_state, 0);
      check("t6_serr_kept", m_serr, 1);
      check("t6_cnt_kept", m_cnt, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
